// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package reg_arb_pkg;

    typedef enum logic {ARB_IDLE = 1'b0, ARB_COOL = 1'b1} arb_state_t;

    // Width needed to index n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid request at or above ptr, wrapping.
module rr_picker
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any_valid
);

    always_comb begin
        int c;
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        c         = 0;
        // Walk the rotated request vector; wrap explicitly so non-power-of-2 counts work.
        for (int k = 0; k < NUM_REQ; k++) begin
            c = int'(ptr) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (!any_valid && req[c]) begin
                any_valid = 1'b1;
                idx       = IDX_W'(c);
                grant[c]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Owns a shared register and grants one write at a time, round-robin,
// followed by a fixed cooldown window.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int                NUM_REQ   = 4,
    parameter int                DATA_W    = 8,
    parameter int                COOLDOWN  = 2,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DATA_W-1:0]            data_out,
    output logic                         wr_strobe,
    output logic [$clog2(NUM_REQ)-1:0]   wr_owner,
    output logic                         busy
);

    localparam int IDX_W = clog2_min1(NUM_REQ);
    localparam int CNT_W = clog2_min1(COOLDOWN + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = (COOLDOWN > 0) ? CNT_W'(COOLDOWN - 1) : '0;

    arb_state_t          state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [IDX_W-1:0]    ptr, ptr_d;
    logic [DATA_W-1:0]   data_d;
    logic [IDX_W-1:0]    owner_d;
    logic                strobe_d;
    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    win_idx;
    logic                any_valid;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .idx       (win_idx),
        .any_valid (any_valid)
    );

    // Ready is masked by rst_n so no grant is offered while reset is held.
    assign req_ready = (state == ARB_IDLE && rst_n) ? grant : '0;
    assign busy      = (state == ARB_COOL);

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        ptr_d    = ptr;
        data_d   = data_out;
        owner_d  = wr_owner;
        strobe_d = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (any_valid) begin
                    data_d   = req_data[win_idx*DATA_W +: DATA_W];
                    strobe_d = 1'b1;
                    owner_d  = win_idx;
                    ptr_d    = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    if (COOLDOWN > 0) begin
                        state_d = ARB_COOL;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ARB_COOL: begin
                if (cnt == '0) state_d = ARB_IDLE;
                else           cnt_d   = cnt - 1'b1;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            cnt       <= '0;
            ptr       <= '0;
            data_out  <= RESET_VAL;
            wr_strobe <= 1'b0;
            wr_owner  <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            ptr       <= ptr_d;
            data_out  <= data_d;
            wr_strobe <= strobe_d;
            wr_owner  <= owner_d;
        end
    end

endmodule
